// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: state encoding, bring-up defaults and field widths shared by the PLL config controller.
package pll_cfg_pkg;
    typedef enum logic [2:0] {S_RST, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL} state_t;
    localparam int DIV_W_DEF = 10;
    localparam int PH_W_DEF  = 13;
    localparam int DEF_IDIV  = 2;
    localparam int DEF_FDIV  = 32;
    localparam int DEF_ODIV  = 100;
    localparam int DEF_DUTY  = 100;
    localparam int DEF_PHASE = 16;
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchroniser bringing the PLL's asynchronous lock into the controller clock domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);
    logic r_meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {o_sync, r_meta} <= 2'b00;
        else        {o_sync, r_meta} <= {r_meta, i_async};
    end
endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: holds the live PLL dynamic configuration and sequences reset, lock qualification and retries.
module pll_dyn_cfg_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 8,
    parameter int MAX_RETRY    = 3,
    parameter int DIV_W        = DIV_W_DEF,
    parameter int PH_W         = PH_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_req,
    output logic             cfg_ack,
    output logic             cfg_rej,
    input  logic [DIV_W-1:0] cfg_idiv,
    input  logic [DIV_W-1:0] cfg_fdiv,
    input  logic [DIV_W-1:0] cfg_odiv0,
    input  logic [DIV_W-1:0] cfg_odiv1,
    input  logic [DIV_W-1:0] cfg_duty0,
    input  logic [DIV_W-1:0] cfg_duty1,
    input  logic [PH_W-1:0]  cfg_phase0,
    input  logic [PH_W-1:0]  cfg_phase1,
    input  logic             pll_lock,
    output logic             pll_rst,
    output logic [DIV_W-1:0] dyn_idiv,
    output logic [DIV_W-1:0] dyn_fdiv,
    output logic [DIV_W-1:0] dyn_odiv0,
    output logic [DIV_W-1:0] dyn_odiv1,
    output logic [DIV_W-1:0] dyn_duty0,
    output logic [DIV_W-1:0] dyn_duty1,
    output logic [PH_W-1:0]  dyn_phase0,
    output logic [PH_W-1:0]  dyn_phase1,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             lock_lost,
    output logic [1:0]       retry_cnt
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    state_t          r_state, w_state;
    logic [RW-1:0]   r_rst_cnt, w_rst_cnt;
    logic [TW-1:0]   r_tmr, w_tmr;
    logic [SW-1:0]   r_stab, w_stab;
    logic [1:0]      w_retry;
    logic            w_err, w_ack, w_rej, w_lost, w_lock_s, w_valid;

    pll_lock_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (pll_lock),
        .o_sync  (w_lock_s)
    );

    // phase offsets may legitimately be zero, so only dividers and duties gate acceptance
    assign w_valid = (cfg_idiv != '0) && (cfg_fdiv != '0) && (cfg_odiv0 != '0) &&
                     (cfg_odiv1 != '0) && (cfg_duty0 != '0) && (cfg_duty1 != '0);
    assign busy    = r_state != S_RUN;
    assign pll_rst = (r_state == S_RST) || (r_state == S_FAIL);

    always_comb begin
        w_state   = r_state;
        w_rst_cnt = r_rst_cnt;
        w_tmr     = r_tmr;
        w_stab    = r_stab;
        w_retry   = retry_cnt;
        w_err     = err;
        w_ack     = 1'b0;
        w_rej     = 1'b0;
        w_lost    = 1'b0;
        case (r_state)
            S_RST: begin
                w_rst_cnt = (r_rst_cnt == RW'(RST_CYCLES - 1)) ? '0 : r_rst_cnt + 1'b1;
                w_tmr     = (r_rst_cnt == RW'(RST_CYCLES - 1)) ? '0 : r_tmr;
                w_state   = (r_rst_cnt == RW'(RST_CYCLES - 1)) ? S_WAIT_LOCK : S_RST;
            end
            S_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state = S_STABLE;
                    w_stab  = SW'(1);
                end else if (r_tmr == TW'(LOCK_TIMEOUT)) begin
                    w_state = (retry_cnt == 2'(MAX_RETRY)) ? S_FAIL : S_RST;
                    w_err   = retry_cnt == 2'(MAX_RETRY);
                    w_retry = (retry_cnt == 2'(MAX_RETRY)) ? retry_cnt : retry_cnt + 2'd1;
                end else begin
                    w_tmr = r_tmr + 1'b1;
                end
            end
            // the timeout timer keeps its value here so a flickering lock cannot extend the budget
            S_STABLE: begin
                w_state = !w_lock_s ? S_WAIT_LOCK : (r_stab >= SW'(LOCK_STABLE - 1)) ? S_RUN : S_STABLE;
                w_stab  = (w_lock_s && r_stab < SW'(LOCK_STABLE - 1)) ? r_stab + 1'b1 : r_stab;
            end
            S_RUN: begin
                if (cfg_req && w_valid) begin
                    w_ack   = 1'b1;
                    w_retry = '0;
                    w_state = S_RST;
                end else begin
                    w_rej   = cfg_req;
                    w_lost  = !w_lock_s;
                    w_retry = !w_lock_s ? '0 : retry_cnt;
                    w_state = !w_lock_s ? S_RST : S_RUN;
                end
            end
            S_FAIL: begin
                w_ack   = cfg_req && w_valid;
                w_rej   = cfg_req && !w_valid;
                w_err   = !w_ack;
                w_retry = w_ack ? '0 : retry_cnt;
                w_state = w_ack ? S_RST : S_FAIL;
            end
            default: w_state = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RST;
            r_rst_cnt  <= '0;
            r_tmr      <= '0;
            r_stab     <= '0;
            retry_cnt  <= '0;
            err        <= 1'b0;
            cfg_ack    <= 1'b0;
            cfg_rej    <= 1'b0;
            done       <= 1'b0;
            lock_lost  <= 1'b0;
            dyn_idiv   <= DIV_W'(DEF_IDIV);
            dyn_fdiv   <= DIV_W'(DEF_FDIV);
            dyn_odiv0  <= DIV_W'(DEF_ODIV);
            dyn_odiv1  <= DIV_W'(DEF_ODIV);
            dyn_duty0  <= DIV_W'(DEF_DUTY);
            dyn_duty1  <= DIV_W'(DEF_DUTY);
            dyn_phase0 <= PH_W'(DEF_PHASE);
            dyn_phase1 <= PH_W'(DEF_PHASE);
        end else begin
            r_state    <= w_state;
            r_rst_cnt  <= w_rst_cnt;
            r_tmr      <= w_tmr;
            r_stab     <= w_stab;
            retry_cnt  <= w_retry;
            err        <= w_err;
            cfg_ack    <= w_ack;
            cfg_rej    <= w_rej;
            done       <= (w_state == S_RUN) && (r_state == S_STABLE);
            lock_lost  <= w_lost;
            if (w_ack) begin
                dyn_idiv   <= cfg_idiv;
                dyn_fdiv   <= cfg_fdiv;
                dyn_odiv0  <= cfg_odiv0;
                dyn_odiv1  <= cfg_odiv1;
                dyn_duty0  <= cfg_duty0;
                dyn_duty1  <= cfg_duty1;
                dyn_phase0 <= cfg_phase0;
                dyn_phase1 <= cfg_phase1;
            end
        end
    end
endmodule

// File: doc/pll_dyn_cfg_ctrl.md
Name: pll_dyn_cfg_ctrl

Overview:
Sequencing controller for the soft PLL's dynamic-configuration inputs.
- Holds the live divider, duty and phase values for the PLL.
- Applies a new configuration on request by resetting the PLL, then waits for a stable lock, with timeout and bounded retry.
- Supervises lock during run and re-locks automatically if lock is lost.
- Sits between the system configuration logic and the PLL instance; pll_rst and dyn_* drive the PLL directly.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset pulse (>=1)
LOCK_TIMEOUT, 65535, cycles allowed in WAIT_LOCK before a retry
LOCK_STABLE, 8, consecutive synced-lock cycles required before RUN
MAX_RETRY, 3, relock attempts after the first before FAIL
DIV_W, 10, width of divider and duty fields
PH_W, 13, width of phase fields

Ports:
clk  in  1  controller clock, free-running and independent of the PLL output
rst_n  in  1  asynchronous active-low reset
cfg_req  in  1  level request to apply cfg_*; held by the requester until cfg_ack
cfg_ack  out  1  one-cycle accept pulse
cfg_rej  out  1  one-cycle pulse: request refused because a field is zero
cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_odiv1, cfg_duty0, cfg_duty1  in  DIV_W each  requested values
cfg_phase0, cfg_phase1  in  PH_W each  requested phases
pll_lock  in  1  asynchronous lock from the PLL
pll_rst  out  1  PLL reset, active high
dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1  out  DIV_W each  registered PLL config
dyn_phase0, dyn_phase1  out  PH_W each  registered phases
busy  out  1  high whenever state is not RUN
done  out  1  one-cycle pulse on entry to RUN
err  out  1  sticky; high in FAIL
lock_lost  out  1  one-cycle pulse when lock drops in RUN
retry_cnt  out  2  retries used in the current attempt

Behaviour:
- Lock synchronisation: pll_lock passes through a 2-FF synchroniser to produce lock_s. All decisions use lock_s, which adds 2 cycles of latency.
- Reset values:
  - state=RST, rst_cnt=0, pll_rst=1, busy=1.
  - dyn_idiv=2, dyn_fdiv=32, dyn_odiv*=100, dyn_duty*=100, dyn_phase*=16.
  - cfg_ack, cfg_rej, done, err and lock_lost = 0; retry_cnt=0.
  - After rst_n deasserts, bring-up runs with these default values.
- State machine: RST, WAIT_LOCK, STABLE, RUN, FAIL.
- RST:
  - pll_rst=1 for exactly RST_CYCLES cycles, counted from entry.
  - Then pll_rst=0, clear the timeout timer, go to WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1: go to STABLE with the stable counter at 1.
  - Timer reaches LOCK_TIMEOUT first, and retry_cnt<MAX_RETRY: increment retry_cnt, go to RST.
  - Timer reaches LOCK_TIMEOUT first, and retry_cnt=MAX_RETRY: go to FAIL, set err=1.
- STABLE:
  - lock_s=1 for LOCK_STABLE consecutive cycles: go to RUN and pulse done.
  - lock_s=0 first: return to WAIT_LOCK. The timeout timer is not cleared.
- RUN:
  - cfg_req=1 with every cfg_* field nonzero (phase fields excluded): pulse cfg_ack.
    - Load all dyn_* from cfg_* in the same edge.
    - retry_cnt=0, go to RST; pll_rst and busy rise on the cycle after acceptance.
  - cfg_req=1 with any divider, duty or odiv field zero: pulse cfg_rej, stay in RUN, dyn_* unchanged.
  - lock_s falls: pulse lock_lost, retry_cnt=0, go to RST with dyn_* unchanged.
  - cfg_req and a lock_s fall in the same cycle: the request wins. cfg_ack is pulsed, lock_lost is not pulsed.
- FAIL:
  - pll_rst=1 is held.
  - cfg_req with valid fields: pulse cfg_ack, load dyn_*, clear err, retry_cnt=0, go to RST.
  - Invalid request: pulse cfg_rej.
- Busy handling: cfg_req in RST, WAIT_LOCK or STABLE is neither acked nor rejected and stays pending. dyn_* change only on an acked edge.
- Counter widths:
  - Timer: $clog2(LOCK_TIMEOUT+1) bits.
  - Stable counter: $clog2(LOCK_STABLE+1) bits.
  - Counters saturate and never wrap.
- Reset mid-operation: asserting rst_n from any state returns immediately to the reset values and restarts bring-up with the defaults.

Decomposition:
- Package pll_cfg_pkg holds:
  - State enum.
  - Default constants DEF_IDIV=2, DEF_FDIV=32, DEF_ODIV=100, DEF_DUTY=100, DEF_PHASE=16.
  - Field-width constants.
- One sub-module, pll_lock_sync: 2-FF synchroniser, reset value 0.

Test Plan:
Use RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, MAX_RETRY=2.
1. Bring-up: rst_n rises, pll_lock rises 10 cycles after pll_rst falls.
   -> pll_rst high for 4 cycles; done pulses 2+8 cycles after pll_lock rises; busy=0; dyn_idiv=2, dyn_odiv0=100.
2. Reconfig: in RUN, cfg_req with cfg_odiv0=200, cfg_duty0=200.
   -> cfg_ack and dyn_odiv0=200 on the next edge; pll_rst=1 for 4 cycles; relock leads to done.
3. Timeout: pll_lock held at 0.
   -> three RST pulses with retry_cnt 0→1→2, then FAIL with err=1 and pll_rst=1.
   -> A valid cfg_req then clears err and restarts the sequence.
4. Lock glitch: lock low for 3 cycles in STABLE.
   -> back to WAIT_LOCK, no done; a later stable lock reaches RUN. In RUN, lock falls -> lock_lost pulse, RST, dyn_* unchanged.
5. Reject and pending:
   -> cfg_fdiv=0 in RUN: cfg_rej pulse, dyn_fdiv stays 32.
   -> cfg_req held during WAIT_LOCK: no ack until RUN, then ack.
6. Async reset mid-WAIT_LOCK after a reconfig to odiv0=200.
   -> dyn_odiv0 returns to 100, pll_rst=1, and bring-up restarts.
